// File: rtl/led_pkg.sv
// Shared definitions for the LED status driver: channel mode encodings,
// default timing constants and a counter-width helper.
package led_pkg;

  typedef logic [1:0] led_mode_t;

  localparam led_mode_t LED_MODE_DIRECT  = 2'b00;
  localparam led_mode_t LED_MODE_STRETCH = 2'b01;
  localparam led_mode_t LED_MODE_BLINK   = 2'b10;
  localparam led_mode_t LED_MODE_STICKY  = 2'b11;

  localparam int LED_STRETCH_CYC_DEF = 5_000_000;
  localparam int LED_BLINK_HALF_DEF  = 12_500_000;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int led_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_ch_ctrl.sv
// One LED channel: edge detect, stretch counter, sticky latch, mode
// register and the per-channel mode mux producing o_y.
module led_ch_ctrl
  import led_pkg::*;
#(
  parameter int STRETCH_CYC = LED_STRETCH_CYC_DEF
) (
  input  logic      fpga_clk,
  input  logic      sys_init_ctrl_n,
  input  logic      i_s,
  input  led_mode_t i_mode,
  input  logic      i_phase,
  input  logic      i_sticky_clr,
  output logic      o_y
);

  localparam int CW = led_cw(STRETCH_CYC);
  localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYC - 1);

  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_st;
  led_mode_t     r_mode;

  logic w_chg;
  logic w_rise;
  logic w_cnt_on;
  logic w_st_on;

  assign w_chg    = (i_mode != r_mode);
  assign w_rise   = i_s & ~r_prev;
  // A mode switch wipes history in the same cycle it is seen.
  assign w_cnt_on = (r_cnt != '0) & ~w_chg;
  assign w_st_on  = r_st & ~w_chg;

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
      r_st   <= 1'b0;
      r_mode <= LED_MODE_DIRECT;
    end else begin
      r_prev <= i_s;
      r_mode <= i_mode;
      if (w_chg)
        r_cnt <= '0;
      else if (w_rise)
        r_cnt <= LOAD;
      else if (r_cnt != '0)
        r_cnt <= r_cnt - CW'(1);
      if (w_chg)
        r_st <= 1'b0;
      else if (i_s)
        r_st <= 1'b1;
      else if (i_sticky_clr)
        r_st <= 1'b0;
    end
  end

  always_comb begin
    o_y = 1'b0;
    unique case (1'b1)
      (i_mode == LED_MODE_DIRECT):  o_y = i_s;
      (i_mode == LED_MODE_STRETCH): o_y = i_s | w_cnt_on;
      (i_mode == LED_MODE_BLINK):   o_y = i_s & i_phase;
      (i_mode == LED_MODE_STICKY):  o_y = w_st_on;
    endcase
  end

endmodule

// File: rtl/led_status_driver.sv
// N-channel LED driver: input stage, shared blink prescaler, output stage.
// Define LED_SYNC_EN to turn the input stage into a 2-flop synchronizer.
module led_status_driver
  import led_pkg::*;
#(
  parameter int N_CH        = 13,
  parameter int STRETCH_CYC = LED_STRETCH_CYC_DEF,
  parameter int BLINK_HALF  = LED_BLINK_HALF_DEF
) (
  input  logic              fpga_clk,
  input  logic              sys_init_ctrl_n,
  input  logic [N_CH-1:0]   status_in,
  input  logic [2*N_CH-1:0] mode_cfg,
  input  logic              sticky_clr,
  input  logic              led_en,
  input  logic              lamp_test,
  output logic [N_CH-1:0]   led_out
);

  localparam int PW = led_cw(BLINK_HALF);
  localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_HALF - 1);

  logic [N_CH-1:0] r_s_q;
  logic [PW-1:0]   r_pre;
  logic            r_phase;
  logic [N_CH-1:0] r_led;
  logic [N_CH-1:0] w_y;

`ifdef LED_SYNC_EN
  logic [N_CH-1:0] r_meta;

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      r_meta <= '0;
      r_s_q  <= '0;
    end else begin
      r_meta <= status_in;
      r_s_q  <= r_meta;
    end
  end
`else
  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n)
      r_s_q <= '0;
    else
      r_s_q <= status_in;
  end
`endif

  // Free-running, independent of any channel mode.
  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      r_pre   <= '0;
      r_phase <= 1'b0;
    end else if (r_pre == PRE_MAX) begin
      r_pre   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_ch_ctrl #(
      .STRETCH_CYC(STRETCH_CYC)
    ) u_ch (
      .fpga_clk        (fpga_clk),
      .sys_init_ctrl_n (sys_init_ctrl_n),
      .i_s             (r_s_q[i]),
      .i_mode          (mode_cfg[2*i +: 2]),
      .i_phase         (r_phase),
      .i_sticky_clr    (sticky_clr),
      .o_y             (w_y[i])
    );
  end

  always_ff @(posedge fpga_clk or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n)
      r_led <= '0;
    else if (lamp_test)
      r_led <= '1;
    else if (led_en)
      r_led <= w_y;
    else
      r_led <= '0;
  end

  assign led_out = r_led;

endmodule

// File: tb/tb_led_status_driver.sv
// Directed scoreboard bench for led_status_driver (N_CH=13,
// STRETCH_CYC=4, BLINK_HALF=3).
module tb_led_status_driver;

  localparam int N  = 13;
  localparam int SC = 4;
  localparam int BH = 3;
`ifdef LED_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] M_DIR = 2'b00;
  localparam logic [1:0] M_STR = 2'b01;
  localparam logic [1:0] M_BLK = 2'b10;
  localparam logic [1:0] M_STK = 2'b11;

  typedef struct {
    string          tag;
    logic [N-1:0]   mask;
    logic [N-1:0]   exp;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   status_in;
  logic [2*N-1:0] mode_cfg;
  logic           sticky_clr;
  logic           led_en;
  logic           lamp_test;
  logic [N-1:0]   led_out;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  led_status_driver #(
    .N_CH(N), .STRETCH_CYC(SC), .BLINK_HALF(BH)
  ) dut (
    .fpga_clk        (clk),
    .sys_init_ctrl_n (rst_n),
    .status_in       (status_in),
    .mode_cfg        (mode_cfg),
    .sticky_clr      (sticky_clr),
    .led_en          (led_en),
    .lamp_test       (lamp_test),
    .led_out         (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input string tag, input logic [N-1:0] mask,
                      input logic [N-1:0] exp);
    exp_t e;
    e.tag  = tag;
    e.mask = mask;
    e.exp  = exp & mask;
    sb.push_back(e);
  endtask

  task automatic pushb(input string tag, input int ch, input logic v);
    logic [N-1:0] m;
    logic [N-1:0] x;
    m = '0;
    x = '0;
    m[ch] = 1'b1;
    x[ch] = v;
    push(tag, m, x);
  endtask

  task automatic chk();
    exp_t         e;
    logic [N-1:0] obs;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h expected=none", led_out);
    end else begin
      e   = sb.pop_front();
      obs = led_out & e.mask;
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode_cfg[2*ch +: 2] = m;
  endtask

  initial begin
    rst_n      = 1'b0;
    status_in  = '1;
    mode_cfg   = '0;
    sticky_clr = 1'b0;
    led_en     = 1'b1;
    lamp_test  = 1'b0;

    // reset with all inputs high
    repeat (3) tick();
    push("reset_low", '1, '0);
    chk();
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= LAT; k++)
      push("direct_rise", '1, (k == LAT) ? '1 : '0);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      chk();
    end
    status_in = '0;
    repeat (LAT + 1) tick();
    push("direct_fall", '1, '0);
    chk();

    // stretch single pulse on ch2
    set_mode(2, M_STR);
    repeat (3) tick();
    status_in[2] = 1'b1;
    for (int k = 1; k <= LAT + 6; k++)
      pushb("stretch_1", 2, (k >= LAT) && (k < LAT + SC));
    for (int k = 1; k <= LAT + 6; k++) begin
      tick();
      if (k == 1) status_in[2] = 1'b0;
      chk();
    end

    // stretch retrigger on the 3rd cycle
    repeat (2) tick();
    status_in[2] = 1'b1;
    for (int k = 1; k <= LAT + 8; k++)
      pushb("stretch_re", 2, (k >= LAT) && (k < LAT + SC + 2));
    for (int k = 1; k <= LAT + 8; k++) begin
      tick();
      if (k == 1) status_in[2] = 1'b0;
      if (k == 2) status_in[2] = 1'b1;
      if (k == 3) status_in[2] = 1'b0;
      chk();
    end

    // blink on ch0, phase tied to prescaler since reset release
    set_mode(0, M_BLK);
    status_in[0] = 1'b1;
    repeat (LAT + 1) tick();
    for (int j = 1; j <= 12; j++)
      pushb("blink_hi", 0, (((cyc + j - 1) / BH) % 2) == 1);
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk();
    end
    status_in[0] = 1'b0;
    repeat (LAT) tick();
    for (int j = 1; j <= 6; j++)
      pushb("blink_lo", 0, 1'b0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      chk();
    end

    // sticky on ch5
    set_mode(5, M_STK);
    repeat (3) tick();
    status_in[5] = 1'b1;
    for (int k = 1; k <= LAT + 3; k++)
      pushb("sticky_set", 5, k >= LAT + 1);
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      if (k == 1) status_in[5] = 1'b0;
      chk();
    end
    repeat (4) tick();
    pushb("sticky_hold", 5, 1'b1);
    chk();

    // clear coincident with a new set: set wins
    status_in[5] = 1'b1;
    for (int k = 1; k <= LAT + 3; k++)
      pushb("sticky_race", 5, 1'b1);
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      if (k == 1) status_in[5] = 1'b0;
      if (k == LAT - 1) sticky_clr = 1'b1;
      if (k == LAT) sticky_clr = 1'b0;
      chk();
    end

    // clear alone
    sticky_clr = 1'b1;
    pushb("sticky_clr", 5, 1'b1);
    pushb("sticky_clr", 5, 1'b0);
    pushb("sticky_clr", 5, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) sticky_clr = 1'b0;
      chk();
    end

    // mode change on ch3: sticky(set) -> direct -> sticky
    set_mode(3, M_STK);
    repeat (3) tick();
    status_in[3] = 1'b1;
    tick();
    status_in[3] = 1'b0;
    repeat (LAT + 2) tick();
    pushb("mchg_set", 3, 1'b1);
    chk();
    set_mode(3, M_DIR);
    pushb("mchg_dir", 3, 1'b0);
    pushb("mchg_dir", 3, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      chk();
    end
    set_mode(3, M_STK);
    for (int k = 1; k <= 3; k++)
      pushb("mchg_back", 3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk();
    end

    // led_en blanking, then lamp test overriding it
    status_in[1] = 1'b1;
    pushb("en_on", 1, 1'b1);
    repeat (LAT) tick();
    chk();
    led_en = 1'b0;
    pushb("en_off", 1, 1'b0);
    tick();
    chk();
    lamp_test    = 1'b1;
    status_in[1] = 1'b0;
    push("lamp_on", '1, '1);
    tick();
    chk();

    // stretch started under lamp test expires on schedule after release
    status_in[2] = 1'b1;
    for (int k = 1; k <= LAT + 5; k++) begin
      logic [N-1:0] x;
      x = '0;
      if (k <= LAT + 1)
        x = '1;
      else if (k < LAT + SC)
        x[2] = 1'b1;
      push("lamp_rel", '1, x);
    end
    for (int k = 1; k <= LAT + 5; k++) begin
      tick();
      if (k == 1) status_in[2] = 1'b0;
      if (k == LAT + 1) begin
        lamp_test = 1'b0;
        led_en    = 1'b1;
      end
      chk();
    end

    // asynchronous reset mid-cycle
    status_in[1] = 1'b1;
    pushb("pre_arst", 1, 1'b1);
    repeat (LAT) tick();
    chk();
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", '1, '0);
    chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_status_driver.md
# led_status_driver

Parametrised front-panel/cover LED driver for N status channels; the next generation of the fixed 4+9 LED register. Each channel has a run-time mode: direct, pulse-stretch, blink or sticky-latch. Short events such as `trg` or `adc_trg` stay visible, and fault-type flags hold until cleared. Sits between system status signals (`sys_init`, `trg`, `rst`, `wrk_stat`, `pause_out`, `adc_trg`, `rf_sw_out`) and the board LED pins, clocked by `fpga_clk`.

## Interface
- `N_CH`, default 13, number of LED channels (≥1).
- `STRETCH_CYC`, default 5_000_000, minimum on-time in cycles for stretch mode (≥1).
- `BLINK_HALF`, default 12_500_000, blink half-period in cycles (≥1).
- `fpga_clk`  in  1  system clock; the only clock.
- `sys_init_ctrl_n`  in  1  reset; asynchronous assert, active-low.
- `status_in`  in  N_CH  raw status bits; bit i drives channel i.
- `mode_cfg`  in  2*N_CH  per-channel mode; bits [2i+1:2i] belong to channel i; quasi-static.
- `sticky_clr`  in  1  one-cycle pulse; clears all sticky latches.
- `led_en`  in  1  global output enable; 0 blanks outputs, internal state keeps running.
- `lamp_test`  in  1  forces all outputs to 1; overrides `led_en`.
- `led_out`  out  N_CH  registered LED drive, active-high.

## Operation
- Modes: 00 DIRECT, 01 STRETCH, 10 BLINK, 11 STICKY.
- Reset: `led_out`=0. Input regs, stretch counters, sticky bits and registered mode copies all 0. Blink prescaler = 0, blink phase = 0.
- Stage 1: `status_in` registered into `s_q`.
  - With `LED_SYNC_EN` this stage is a 2-flop synchronizer instead of 1 flop.
- DIRECT: `y = s_q[i]`.
- STRETCH:
  - Rising edge of `s_q[i]` (prev 0, now 1) loads counter with STRETCH_CYC-1.
  - Otherwise the counter decrements while nonzero.
  - `y = s_q[i] | (cnt≠0)`.
  - A retrigger while counting reloads the counter.
  - Counter width is $clog2(STRETCH_CYC); no wrap, it saturates at 0.
- BLINK: `y = s_q[i] & phase`.
  - A shared prescaler counts 0..BLINK_HALF-1, then wraps to 0 and toggles `phase`.
  - The prescaler free-runs regardless of modes.
- STICKY: `st[i]` set when `s_q[i]=1`, cleared by `sticky_clr`; `y = st[i]`.
  - Set and clear in the same cycle: set wins, `st` stays 1.
- Mode change: when `mode_cfg` field i differs from its registered copy, channel i's stretch counter and sticky bit are cleared that cycle. The new mode applies from that cycle.
- Output stage: `led_out[i] <= lamp_test ? 1 : (led_en ? y : 0)`.
- Reset mid-operation clears everything immediately (async); outputs go low without waiting for a clock edge.

## Timing
- Latency: `status_in` change to `led_out` is 2 cycles in DIRECT, 3 cycles with `LED_SYNC_EN`.
- STRETCH, 1-cycle input pulse: `led_out` high for exactly STRETCH_CYC cycles.
- STRETCH, input high for H cycles: `led_out` high for max(H, STRETCH_CYC) cycles.
- BLINK with input held high: `led_out` toggles every BLINK_HALF cycles; full period 2*BLINK_HALF.
- `sticky_clr` at edge k: output low at edge k+1 if input is low.
- `led_en` and `lamp_test` take effect 1 cycle after sampling.
- No handshakes; all inputs are level-sampled every cycle.

## Configuration
- `LED_SYNC_EN` defined: `status_in` passes through a 2-flop synchronizer (asynchronous sources allowed); latency +1.
- `LED_SYNC_EN` undefined: single register stage; `status_in` must be synchronous to `fpga_clk`.

## Structure
- Shared package `led_pkg`: mode constants `LED_MODE_DIRECT/STRETCH/BLINK/STICKY` (2-bit), mode typedef, default `STRETCH_CYC`/`BLINK_HALF` values.
- Top-level `led_status_driver` owns: input stage, shared blink prescaler/phase, output stage.
- Sub-module `led_ch_ctrl`, generated N_CH times: holds edge detect, stretch counter, sticky bit, mode register and mode mux; outputs `y`.

## Test plan
- Reset with `status_in`=all 1, then release -> `led_out`=0 during reset; DIRECT channels go high 2 cycles after release.
- STRETCH, STRETCH_CYC=4, 1-cycle pulse on ch2 -> `led_out[2]` high exactly 4 cycles. Retrigger at 3rd cycle -> high 6 cycles total.
- BLINK, BLINK_HALF=3, ch0 held high -> `led_out[0]` pattern 000111000111…, aligned to prescaler wrap. Input low -> constant 0.
- STICKY: ch5 pulsed once -> stays 1. `sticky_clr` coincident with new pulse -> stays 1. `sticky_clr` alone -> 0 one cycle later.
- Mode change on ch3 from STICKY(set) to DIRECT with input 0 -> `led_out[3]` drops. Switching back to STICKY does not restore the old latch.
- `lamp_test`=1 with `led_en`=0 -> all N_CH outputs 1. Release -> outputs 0. Stretch counter started before release still expires on schedule.
